// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 16-bit instructions over a request/ready handshake and
// hands them to decode over valid/ready, applying jump/branch redirects on accept.
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] instr,
   output logic [3:0]  opcode,
   output logic [15:0] pc_out,
   input  logic        jump,
   input  logic        branch_taken
);
   typedef enum logic [1:0] {RESET_WAIT, FETCH, HOLD} state_t;
   state_t state;
   logic [15:0] pc;
   logic [15:0] next_pc;
   assign imem_addr = pc;
   assign opcode = instr[15:12];
   // jump keeps the page of the held instruction; branch offset is a signed nibble
   assign next_pc = jump ? {pc_out[15:12], instr[11:0]}
                  : branch_taken ? pc_out + 16'd1 + {{12{instr[3]}}, instr[3:0]}
                  : pc_out + 16'd1;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= RESET_WAIT;
         pc          <= RESET_PC;
         pc_out      <= RESET_PC;
         instr       <= 16'h0000;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            RESET_WAIT: begin
               state    <= FETCH;
               imem_req <= 1'b1;
            end
            FETCH: if (imem_ready) begin
               instr       <= imem_rdata;
               pc_out      <= pc;
               imem_req    <= 1'b0;
               instr_valid <= 1'b1;
               state       <= HOLD;
            end
            HOLD: if (instr_ready) begin
               pc          <= next_pc;
               instr_valid <= 1'b0;
               imem_req    <= 1'b1;
               state       <= FETCH;
            end
            default: begin
               state       <= RESET_WAIT;
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized fetch/redirect sequences checked
// against an arithmetic next-pc model.
module tb_instr_fetch_unit;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [15:0] imem_rdata = 16'h0000;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic [15:0] pc_out;
   logic        jump = 1'b0;
   logic        branch_taken = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [15:0] exp_pc;

   instr_fetch_unit #(.RESET_PC(16'h0010)) dut (
      .clock(clock), .reset_n(reset_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .opcode(opcode), .pc_out(pc_out),
      .jump(jump), .branch_taken(branch_taken)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] ref_next(logic [15:0] pco, logic [15:0] ir, bit j, bit b);
      int off;
      int n;
      off = int'(ir & 16'h000F);
      if (off > 7) off -= 16;
      if (j) return (pco & 16'hF000) | (ir & 16'h0FFF);
      n = int'(pco) + 1 + (b ? off : 0);
      return 16'(n & 32'hFFFF);
   endfunction

   task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Entry: just after an edge with a request expected on exp_pc. Exit: same, after accept.
   task automatic fetch(logic [15:0] data, int waits, int stall, bit j, bit b);
      logic [15:0] fetched_at;
      fetched_at = exp_pc;
      check("req_on_entry", imem_req, 1);
      check("addr_on_entry", imem_addr, exp_pc);
      for (int i = 0; i < waits; i++) begin
         imem_ready = 1'b0;
         jump = 1'($urandom);
         branch_taken = 1'($urandom);
         tick();
         check("wait_req", imem_req, 1);
         check("wait_addr", imem_addr, exp_pc);
         check("wait_valid", instr_valid, 0);
      end
      imem_ready = 1'b1;
      imem_rdata = data;
      tick();
      imem_ready = 1'b0;
      check("fetch_valid", instr_valid, 1);
      check("fetch_req", imem_req, 0);
      check("fetch_instr", instr, data);
      check("fetch_opcode", 16'(opcode), 16'(data >> 12));
      check("fetch_pc_out", pc_out, fetched_at);
      for (int i = 0; i < stall; i++) begin
         instr_ready = 1'b0;
         jump = 1'($urandom);
         branch_taken = 1'($urandom);
         imem_ready = 1'($urandom);
         imem_rdata = 16'($urandom);
         tick();
         check("stall_valid", instr_valid, 1);
         check("stall_req", imem_req, 0);
         check("stall_instr", instr, data);
         check("stall_pc_out", pc_out, fetched_at);
      end
      imem_ready = 1'b0;
      instr_ready = 1'b1;
      jump = j;
      branch_taken = b;
      tick();
      instr_ready = 1'b0;
      jump = 1'b0;
      branch_taken = 1'b0;
      exp_pc = ref_next(fetched_at, data, j, b);
      check("accept_valid", instr_valid, 0);
      check("accept_req", imem_req, 1);
      check("accept_addr", imem_addr, exp_pc);
   endtask

   initial begin
      // boot
      #1;
      check("rst_req", imem_req, 0);
      check("rst_valid", instr_valid, 0);
      repeat (3) begin
         tick();
         check("rst_hold_req", imem_req, 0);
         check("rst_hold_valid", instr_valid, 0);
      end
      reset_n = 1'b1;
      tick();
      exp_pc = 16'h0010;
      // sequential stream with two wait states
      fetch(16'h1234, 2, 0, 0, 0);
      fetch(16'h2345, 2, 0, 0, 0);
      fetch(16'h3456, 2, 0, 0, 0);
      check("seq_next_addr", imem_addr, 16'h0013);
      // jump to 0x0000, branch back to 0xFFFF, wrap, then jump with top nibble F
      fetch(16'h0000, 0, 0, 1, 0);
      check("jump_zero", imem_addr, 16'h0000);
      fetch(16'h400E, 1, 0, 0, 1);
      check("branch_neg_wrap", imem_addr, 16'hFFFF);
      fetch(16'h7777, 0, 0, 0, 0);
      check("pc_wrap", imem_addr, 16'h0000);
      fetch(16'h400E, 0, 0, 0, 1);
      fetch(16'h0ABC, 0, 0, 1, 1);
      check("jump_wins", imem_addr, 16'hFABC);
      fetch(16'h412E, 0, 0, 0, 1);
      check("branch_minus2", imem_addr, 16'hFABB);
      // stall with toggling jump; only accept-cycle values count
      fetch(16'h5123, 0, 5, 0, 0);
      check("stall_no_redirect", imem_addr, 16'hFABC);
      fetch(16'h6321, 1, 5, 1, 0);
      check("stall_jump", imem_addr, 16'hF321);
      for (int k = 0; k < 30; k++)
         fetch(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom));
      // reset during fetch wait, with a late response
      imem_ready = 1'b0;
      #1;
      reset_n = 1'b0;
      #1;
      check("midfetch_req_drop", imem_req, 0);
      check("midfetch_valid", instr_valid, 0);
      imem_ready = 1'b1;
      imem_rdata = 16'hDEAD;
      tick();
      reset_n = 1'b1;
      tick();
      check("late_ready_valid", instr_valid, 0);
      check("restart_req", imem_req, 1);
      check("restart_addr", imem_addr, 16'h0010);
      imem_ready = 1'b0;
      exp_pc = 16'h0010;
      fetch(16'h9876, 1, 1, 0, 0);
      // reset during hold
      imem_ready = 1'b1;
      imem_rdata = 16'hBEEF;
      tick();
      imem_ready = 1'b0;
      check("hold_valid", instr_valid, 1);
      reset_n = 1'b0;
      #1;
      check("midhold_valid_drop", instr_valid, 0);
      check("midhold_ir_reset", instr, 16'h0000);
      check("midhold_req", imem_req, 0);
      tick();
      reset_n = 1'b1;
      tick();
      exp_pc = 16'h0010;
      fetch(16'hC001, 0, 0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch sequencer that produces the 16-bit instruction stream consumed by the control unit's 4-bit opcode decode. It holds the program counter, issues word reads to instruction memory over a request/ready handshake, and presents each instruction to decode over a valid/ready handshake. It applies the jump and branch redirects that decode reports back for the instruction it currently holds.

## Interface
- RESET_PC, 16'h0000, program counter value loaded on reset.
- clock  in  1  single system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  16  word address of the request; equals pc.
- imem_ready  in  1  memory returns imem_rdata this cycle; completes the request.
- imem_rdata  in  16  instruction word, valid when imem_ready=1.
- instr_valid  out  1  instr/opcode/pc_out hold a fetched instruction.
- instr_ready  in  1  decode accepts the held instruction.
- instr  out  16  instruction register (IR).
- opcode  out  4  IR[15:12]; feeds the control unit.
- pc_out  out  16  address the held instruction was fetched from.
- jump  in  1  held instruction is a jump; sampled only on accept.
- branch_taken  in  1  held instruction is a branch with a true condition; sampled only on accept.

## Operation
- Instruction fields: [15:12] opcode, [11:0] jump target, [3:0] signed branch offset.
- FSM has three states: RESET_WAIT, FETCH, HOLD.
- RESET_WAIT is entered asynchronously on reset. Reset values: pc=RESET_PC, IR=16'h0000, imem_req=0, instr_valid=0.
- The first clock edge with reset_n=1 moves the FSM to FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - Both signals stay stable until imem_ready=1.
  - When imem_ready=1 at an edge, imem_rdata is loaded into IR, pc_out is set to pc, and the FSM moves to HOLD.
- HOLD:
  - instr_valid=1 and imem_req=0.
  - IR and pc_out stay stable while instr_ready=0.
  - An accept is instr_valid & instr_ready at an edge. On accept, the next pc is:
    - jump=1: {pc_out[15:12], IR[11:0]}. Jump has priority over branch_taken.
    - else branch_taken=1: pc_out + 1 + sign_extend(IR[3:0]), modulo 2^16.
    - else: pc_out + 1, modulo 2^16. 16'hFFFF wraps to 16'h0000.
  - After the accept the FSM returns to FETCH.
- jump and branch_taken are ignored in every cycle that is not an accept.
- At most one instruction is outstanding. The unit never issues a request while holding an instruction.
- imem_ready asserted outside FETCH is ignored.
- Reset asserted mid-request or mid-hold:
  - All outputs return to reset values immediately.
  - The pending memory response is discarded.
  - After release, fetch restarts at RESET_PC.

## Timing
- Reset release to first imem_req=1: 1 clock edge.
- Fetch latency: instr_valid rises on the edge where imem_ready=1 is sampled. A zero-wait memory (imem_ready=1 in the first FETCH cycle) therefore gives instr_valid one cycle after imem_req rises.
- Accept to next imem_req: the next edge. imem_addr already carries the redirected pc in that cycle.
- Maximum throughput: one instruction per 2 cycles (FETCH, HOLD) with zero-wait memory and instr_ready=1.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.

## Test plan
- Reset/boot: RESET_PC=16'h0010, reset_n low for 3 cycles, then high.
  - Required: imem_req=0 and instr_valid=0 during reset.
  - Required: imem_req=1 with imem_addr=16'h0010 one edge after release.
- Sequential stream: memory with 2 wait states returns 16'h1234, 16'h2345, 16'h3456; instr_ready=1.
  - Required: opcode sequence 1, 2, 3.
  - Required: pc_out sequence 0010, 0011, 0012.
  - Required: imem_addr stable through the wait states.
- Jump and branch:
  - IR=16'h0ABC at pc_out=16'h5000, jump=1 on accept → next imem_addr=16'h5ABC.
  - IR=16'h412E at pc_out=16'h0020, branch_taken=1 → next imem_addr=16'h001F (0x20+1−2).
  - jump=1 and branch_taken=1 together → jump target wins.
- Decode stall: instr_ready=0 for 5 cycles while jump toggles.
  - Required: instr, pc_out and opcode stable and imem_req=0 throughout.
  - Required: only the jump value on the accept cycle affects the next pc.
- Wrap-around: pc_out=16'hFFFF accepted with no redirect → next imem_addr=16'h0000.
- Reset mid-operation:
  - Assert reset_n=0 during FETCH wait. Required: imem_req drops with no clock edge.
  - Assert reset_n=0 during HOLD. Required: instr_valid drops with no clock edge.
  - After release, fetch restarts at RESET_PC. A late imem_ready is ignored.
